// File: rtl/mul_pkg.sv
// Shared definitions for the multiply issue path: opcodes, multiplier sign controls, FSM states.
package mul_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned TAGW = 5;

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulh   = 2'b01;
    localparam logic [1:0] OpMulhsu = 2'b10;
    localparam logic [1:0] OpMulhu  = 2'b11;

    // Bit 1 qualifies mul_a, bit 0 qualifies mul_b.
    localparam logic [1:0] SgnSS = 2'b11;
    localparam logic [1:0] SgnSU = 2'b10;
    localparam logic [1:0] SgnUU = 2'b00;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    function automatic logic [1:0] op_signed(input logic [1:0] op, input logic w);
        logic [1:0] sgn;
        if (w) begin
            sgn = SgnSS;
        end else begin
            unique case (op)
                OpMul, OpMulh: sgn = SgnSS;
                OpMulhsu:      sgn = SgnSU;
                default:       sgn = SgnUU;
            endcase
        end
        return sgn;
    endfunction

endpackage

// File: rtl/mul_issue_if.sv
// Request, multiplier and writeback signals of the multiply issue controller.
interface mul_issue_if;
    import mul_pkg::*;

    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic            req_w;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic [TAGW-1:0] req_tag;

    logic            mul_in_valid;
    logic            mul_flush;
    logic            mul_w;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic            mul_out_ready;
    logic            mul_out_valid;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_lo;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [TAGW-1:0] resp_tag;

    modport slave (
        input  flush, req_valid, req_op, req_w, req_src1, req_src2, req_tag,
               mul_out_ready, mul_out_valid, mul_hi, mul_lo, resp_ready,
        output req_ready, mul_in_valid, mul_flush, mul_w, mul_signed, mul_a, mul_b,
               resp_valid, resp_data, resp_tag
    );

    modport master (
        output flush, req_valid, req_op, req_w, req_src1, req_src2, req_tag,
               mul_out_ready, mul_out_valid, mul_hi, mul_lo, resp_ready,
        input  req_ready, mul_in_valid, mul_flush, mul_w, mul_signed, mul_a, mul_b,
               resp_valid, resp_data, resp_tag
    );

endinterface

// File: rtl/mul_res_fmt.sv
// Selects the architectural result from the multiplier halves and sign-extends word ops.
module mul_res_fmt
    import mul_pkg::*;
(
    input  logic [1:0]      op_i,
    input  logic            w_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    output logic [XLEN-1:0] res_o
);

    always_comb begin
        res_o = hi_i;
        if (w_i) begin
            res_o = sext32(lo_i[31:0]);
        end else if (op_i == OpMul) begin
            res_o = lo_i;
        end
    end

endmodule

// File: rtl/mul_issue.sv
// Issue/writeback controller between EXU decode and the radix-4 Booth multiplier.
module mul_issue
    import mul_pkg::*;
(
    input logic         clock,
    input logic         reset,
    mul_issue_if.slave  bus
);

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            w_q, w_d;
    logic [1:0]      sgn_q, sgn_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] fmt_res;
    logic            in_valid;
    logic            flush_pulse;

    mul_res_fmt u_res_fmt (
        .op_i  (op_q),
        .w_i   (w_q),
        .hi_i  (bus.mul_hi),
        .lo_i  (bus.mul_lo),
        .res_o (fmt_res)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpMul;
            w_q     <= 1'b0;
            sgn_q   <= SgnUU;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            w_q     <= w_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        w_d         = w_q;
        sgn_d       = sgn_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        res_d       = res_q;
        in_valid    = 1'b0;
        flush_pulse = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && !bus.flush) begin
                    state_d = StIssue;
                    // A word request is always MULW regardless of the opcode field.
                    w_d     = bus.req_w;
                    op_d    = bus.req_w ? OpMul : bus.req_op;
                    sgn_d   = op_signed(bus.req_op, bus.req_w);
                    a_d     = bus.req_w ? sext32(bus.req_src1[31:0]) : bus.req_src1;
                    b_d     = bus.req_w ? sext32(bus.req_src2[31:0]) : bus.req_src2;
                    tag_d   = bus.req_tag;
                end
            end
            StIssue: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (bus.mul_out_ready) begin
                    in_valid = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (bus.flush) begin
                    flush_pulse = 1'b1;
                    state_d     = StDrain;
                end else if (bus.mul_out_valid) begin
                    res_d   = fmt_res;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.flush || bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                // A stale result may still pop out while the multiplier winds down.
                if (bus.mul_out_ready && !bus.mul_out_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req_ready    = (state_q == StIdle);
    assign bus.mul_in_valid = in_valid;
    assign bus.mul_flush    = flush_pulse;
    assign bus.mul_w        = w_q;
    assign bus.mul_signed   = sgn_q;
    assign bus.mul_a        = a_q;
    assign bus.mul_b        = b_q;
    assign bus.resp_valid   = (state_q == StDone);
    assign bus.resp_data    = res_q;
    assign bus.resp_tag     = tag_q;

endmodule

// File: tb/tb_mul_issue.sv
// Randomized scoreboard bench for mul_issue with a behavioural multiplier alongside.
module tb_mul_issue;
    import mul_pkg::*;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mul_issue_if bus ();

    mul_issue dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   iv_cnt = 0;
    int   fl_cnt = 0;

    // Behavioural multiplier: fixed latency, idle when not busy, killed by mul_flush.
    int           m_lat = 3;
    int           m_cnt = 0;
    logic         m_busy = 1'b0;
    logic [127:0] m_p = '0;

    function automatic logic [127:0] ext(input logic [63:0] x, input logic s);
        return {{64{s & x[63]}}, x};
    endfunction

    assign bus.mul_out_ready = !m_busy;

    always @(posedge clock) begin
        bus.mul_out_valid <= 1'b0;
        if (reset || bus.mul_flush) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy            <= 1'b0;
                bus.mul_out_valid <= 1'b1;
                bus.mul_hi        <= m_p[127:64];
                bus.mul_lo        <= m_p[63:0];
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (bus.mul_in_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= m_lat - 1;
            m_p    <= ext(bus.mul_a, bus.mul_signed[1]) * ext(bus.mul_b, bus.mul_signed[0]);
        end
    end

    // Architectural reference straight from the RISC-V M definitions.
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  r;
        if (w) begin
            p = {{96{a[31]}}, a[31:0]} * {{96{b[31]}}, b[31:0]};
            r = {{32{p[31]}}, p[31:0]};
        end else begin
            case (op)
                2'b00:   begin p = ext(a, 1'b0) * ext(b, 1'b0); r = p[63:0];   end
                2'b01:   begin p = ext(a, 1'b1) * ext(b, 1'b1); r = p[127:64]; end
                2'b10:   begin p = ext(a, 1'b1) * ext(b, 1'b0); r = p[127:64]; end
                default: begin p = ext(a, 1'b0) * ext(b, 1'b0); r = p[127:64]; end
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.mul_in_valid) iv_cnt++;
            if (bus.mul_flush) fl_cnt++;
            if (bus.resp_valid && bus.resp_ready && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected resp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_tag", 64'(bus.resp_tag), 64'(e.tag));
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst req_ready", 64'(bus.req_ready), 64'd1);
        check("rst mul_in_valid", 64'(bus.mul_in_valid), 64'd0);
        check("rst mul_flush", 64'(bus.mul_flush), 64'd0);
        check("rst mul_w", 64'(bus.mul_w), 64'd0);
        check("rst mul_signed", 64'(bus.mul_signed), 64'd0);
        check("rst mul_a", bus.mul_a, 64'd0);
        check("rst mul_b", bus.mul_b, 64'd0);
        check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst resp_data", bus.resp_data, 64'd0);
        check("rst resp_tag", 64'(bus.resp_tag), 64'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 with the request accepted (block in ISSUE).
    task automatic send(input logic [1:0] op, input logic w, input logic [63:0] s1,
                        input logic [63:0] s2, input logic [TAGW-1:0] tag, output bit ok);
        int   n = 0;
        exp_t e;
        logic [1:0] sgn;
        while (!bus.req_ready && n < 100) begin
            @(posedge clock); #1; n++;
        end
        ok = bus.req_ready;
        if (!ok) begin
            check("req_ready timeout", 64'd0, 64'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_w     = w;
        bus.req_src1  = s1;
        bus.req_src2  = s2;
        bus.req_tag   = tag;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        e.tag  = tag;
        e.data = ref_res(op, w, s1, s2);
        exp_q.push_back(e);
        case (op)
            2'b00, 2'b01: sgn = 2'b11;
            2'b10:        sgn = 2'b10;
            default:      sgn = 2'b00;
        endcase
        if (w) sgn = 2'b11;
        check("mul_signed", 64'(bus.mul_signed), 64'(sgn));
        check("mul_w", 64'(bus.mul_w), 64'(w));
        check("mul_a", bus.mul_a, w ? {{32{s1[31]}}, s1[31:0]} : s1);
        check("mul_b", bus.mul_b, w ? {{32{s2[31]}}, s2[31:0]} : s2);
    endtask

    task automatic wait_resp(output bit ok);
        int n = 0;
        while (!bus.resp_valid && n < 200) begin
            @(posedge clock); #1; n++;
        end
        ok = bus.resp_valid;
        if (!ok) check("resp_valid timeout", 64'd0, 64'd1);
    endtask

    task automatic accept(input int hold);
        for (int i = 0; i < hold; i++) begin
            check("hold resp_valid", 64'(bus.resp_valid), 64'd1);
            if (exp_q.size() != 0) check("hold resp_data", bus.resp_data, exp_q[0].data);
            check("hold req_ready", 64'(bus.req_ready), 64'd0);
            @(posedge clock); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
        check("idle after xfer", 64'(bus.req_ready), 64'd1);
        check("resp_valid drop", 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic w, input logic [63:0] s1,
                         input logic [63:0] s2, input logic [TAGW-1:0] tag, input int hold);
        int iv0;
        bit ok;
        iv0 = iv_cnt;
        send(op, w, s1, s2, tag, ok);
        if (!ok) return;
        wait_resp(ok);
        if (!ok) begin
            void'(exp_q.pop_front());
            return;
        end
        accept(hold);
        check("in_valid pulses", 64'(iv_cnt - iv0), 64'd1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'd0;
            3:       return 64'h0000_0000_7FFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bit ok;
        int iv0;
        int fl0;
        bit seen;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_w      = 1'b0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        bus.mul_out_valid = 1'b0;
        bus.mul_hi = '0;
        bus.mul_lo = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed arithmetic cases.
        m_lat = 3;
        do_op(OpMul, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd5, 0);
        do_op(OpMulh, 1'b0, '1, '1, 5'd6, 1);
        do_op(OpMulhu, 1'b0, '1, 64'd2, 5'd7, 0);
        do_op(OpMulhsu, 1'b0, '1, 64'd2, 5'd8, 2);
        do_op(OpMul, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 5'd9, 0);

        // Writeback backpressure.
        do_op(OpMul, 1'b0, 64'hDEAD_BEEF, 64'h1_0001, 5'd10, 10);

        // Flush while IDLE with a request present: nothing accepted.
        iv0 = iv_cnt;
        bus.req_valid = 1'b1;
        bus.req_src1  = 64'd7;
        bus.req_src2  = 64'd7;
        bus.flush     = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle flush req_ready", 64'(bus.req_ready), 64'd1);
        check("idle flush no issue", 64'(iv_cnt - iv0), 64'd0);

        // Flush in WAIT.
        m_lat = 12;
        fl0 = fl_cnt;
        iv0 = iv_cnt;
        send(OpMulhu, 1'b0, '1, '1, 5'd11, ok);
        if (ok) begin
            repeat (5) @(posedge clock);
            #1;
            bus.flush = 1'b1;
            void'(exp_q.pop_back());
            @(posedge clock); #1;
            bus.flush = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus.resp_valid) seen = 1'b1;
                @(posedge clock); #1;
            end
            check("wait flush no resp", 64'(seen), 64'd0);
            check("wait flush pulses", 64'(fl_cnt - fl0), 64'd1);
            check("wait flush issued", 64'(iv_cnt - iv0), 64'd1);
        end
        m_lat = 4;
        do_op(OpMul, 1'b0, 64'd4, 64'd5, 5'd12, 0);

        // Flush in DONE together with resp_ready: result dropped.
        send(OpMul, 1'b0, 64'd9, 64'd9, 5'd13, ok);
        if (ok) begin
            wait_resp(ok);
            void'(exp_q.pop_back());
            bus.flush      = 1'b1;
            bus.resp_ready = 1'b1;
            @(posedge clock); #1;
            bus.flush      = 1'b0;
            bus.resp_ready = 1'b0;
            check("done flush resp_valid", 64'(bus.resp_valid), 64'd0);
            check("done flush req_ready", 64'(bus.req_ready), 64'd1);
        end

        // Reset while WAIT.
        m_lat = 10;
        send(OpMulh, 1'b0, 64'h1234, 64'h5678, 5'd14, ok);
        if (ok) begin
            repeat (3) @(posedge clock);
            #1;
            void'(exp_q.pop_back());
            reset = 1'b1;
            @(posedge clock); #1;
            check_reset_outputs();
            reset = 1'b0;
            @(posedge clock); #1;
        end

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic       w;
            op    = 2'($urandom_range(0, 3));
            w     = ($urandom_range(0, 3) == 0);
            m_lat = $urandom_range(1, 6);
            do_op(op, w, pick(), pick(), 5'($urandom), $urandom_range(0, 3));
        end

        repeat (2) @(posedge clock);
        #1;
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
